fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Owns the program counter and drives the instruction-memory address.
- Registers the fetched word into the IF/ID pipeline register, which feeds the decode/control stage.
- Honours load-use stalls from the hazard unit and branch-taken flushes from the control unit (PC_MUX_op).
- Keeps fetch and flush statistics counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUBBLE_INST, 32'h0000_0000, instruction word inserted as a bubble; the decoder reports all-zero opcode as not valid
CNT_W, 16, width of the statistics counters

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  run enable; PC advances only when high
stall_i  in  1  hold PC and IF/ID (load-use hazard)
flush_i  in  1  branch taken; redirect PC and squash IF/ID (driven from PC_MUX_op)
branch_target_i  in  32  redirect address, valid when flush_i=1
imem_addr_o  out  32  instruction-memory address (combinational, = PC)
imem_data_i  in  32  instruction word at imem_addr_o, same cycle (combinational memory)
pc_o  out  32  IF/ID register: PC of held instruction
inst_o  out  32  IF/ID register: instruction word
valid_o  out  1  IF/ID register: 1 = real instruction, 0 = bubble
fetch_count_o  out  CNT_W  number of instructions loaded into IF/ID
flush_count_o  out  CNT_W  number of flushes taken

Behaviour:
Reset:
- rst_i=1 at an edge sets pc=RESET_PC, pc_o=0, inst_o=BUBBLE_INST, valid_o=0, and both counters to 0.
- Reset overrides every other input, including mid-stall or mid-flush.

Outputs:
- imem_addr_o = pc at all times (no latency).
- All other outputs come straight from registers.

Per-edge priority (highest first):
1. rst_i = 1: reset as above.
2. start_i = 0: pc held; IF/ID loads a bubble (pc_o=0, inst_o=BUBBLE_INST, valid_o=0); stall_i and flush_i ignored; counters held.
3. flush_i = 1: pc <= {branch_target_i[31:2], 2'b00}; IF/ID loads a bubble; flush_count_o increments.
   - Flush wins over a simultaneous stall_i=1.
   - fetch_count_o is not incremented.
4. stall_i = 1: pc, pc_o, inst_o and valid_o all held unchanged; counters held.
   - A multi-cycle stall holds indefinitely with no duplication and no loss.
5. Normal: pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0); IF/ID <= {pc, imem_data_i, 1}; fetch_count_o increments.

Timing and arithmetic:
- Latency: an instruction at address A is visible on inst_o/pc_o exactly one edge after imem_addr_o = A.
- Counters saturate at all-ones; they do not wrap.
- PC is always word-aligned; the low two bits of every PC value are 0.
- The downstream register enable follows valid_o only; this block does not decode instructions.

Test Plan:
1. Reset then start_i=1 with imem returning 0x00A00093 at 0, 0x00100113 at 4 -> after edge 1: pc_o=0, inst_o=0x00A00093, valid_o=1; after edge 2: pc_o=4, inst_o=0x00100113; fetch_count_o=2.
2. Stall: at pc=8 assert stall_i for 3 cycles -> imem_addr_o stays 8; pc_o=4 and inst_o unchanged for 3 edges; the cycle after release loads pc_o=8; fetch_count_o does not increase during the stall.
3. Flush: at pc=0x10 assert flush_i with branch_target_i=0x40 -> next edge: imem_addr_o=0x40, valid_o=0, inst_o=0, flush_count_o=1; following edge: pc_o=0x40, valid_o=1.
4. Flush and stall together, plus misaligned target: stall_i=1, flush_i=1, branch_target_i=0x23 -> pc=0x20, bubble loaded; stall has no effect that cycle.
5. Wrap and start: force pc to 0xFFFF_FFFC, one normal edge -> pc=0, pc_o=0xFFFF_FFFC; then start_i=0 for 2 edges -> pc holds at 0, valid_o=0, and flush_i=1 during these edges is ignored.
6. Reset mid-stall: stall_i=1 with valid_o=1, assert rst_i for one edge -> pc=RESET_PC, valid_o=0, inst_o=0, both counters 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem address, registers the fetched word into IF/ID (one-edge latency).
// Backpressure: stall_i freezes PC and IF/ID; flush_i redirects PC and loads a bubble; start_i=0 idles with bubbles.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INST = 32'h0000_0000,
    parameter int          CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      branch_target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      inst_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] fetch_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    logic [31:0] pc;

    assign imem_addr_o = pc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc            <= {RESET_PC[31:2], 2'b00};
            pc_o          <= 32'h0000_0000;
            inst_o        <= BUBBLE_INST;
            valid_o       <= 1'b0;
            fetch_count_o <= '0;
            flush_count_o <= '0;
        end else if (!start_i) begin
            pc_o    <= 32'h0000_0000;
            inst_o  <= BUBBLE_INST;
            valid_o <= 1'b0;
        end else if (flush_i) begin
            // Redirect wins over a concurrent stall; the target is forced word-aligned.
            pc      <= {branch_target_i[31:2], 2'b00};
            pc_o    <= 32'h0000_0000;
            inst_o  <= BUBBLE_INST;
            valid_o <= 1'b0;
            if (~&flush_count_o) begin
                flush_count_o <= flush_count_o + 1'b1;
            end
        end else if (!stall_i) begin
            pc      <= pc + 32'd4;
            pc_o    <= pc;
            inst_o  <= imem_data_i;
            valid_o <= 1'b1;
            if (~&fetch_count_o) begin
                fetch_count_o <= fetch_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed plan steps then random control traffic against a behavioural model.
module tb_fetch_stage;

    localparam int          CW     = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] BUBBLE = 32'h0000_0000;
    localparam int          CMAX   = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i, start_i, stall_i, flush_i;
    logic [31:0]   branch_target_i, imem_addr_o, imem_data_i, pc_o, inst_o;
    logic          valid_o;
    logic [CW-1:0] fetch_count_o, flush_count_o;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_pc_o, m_inst;
    logic        m_valid;
    int          m_fc, m_flc;

    fetch_stage #(.RESET_PC(RST_PC), .BUBBLE_INST(BUBBLE), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .flush_i(flush_i), .branch_target_i(branch_target_i),
        .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
        .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o),
        .fetch_count_o(fetch_count_o), .flush_count_o(flush_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h00A0_0093;
        else if (a == 32'h4) return 32'h0010_0113;
        else                 return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    assign imem_data_i = imem_word(imem_addr_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst_i) begin
            m_pc = RST_PC; m_pc_o = 0; m_inst = BUBBLE; m_valid = 0; m_fc = 0; m_flc = 0;
        end else if (!start_i) begin
            m_pc_o = 0; m_inst = BUBBLE; m_valid = 0;
        end else if (flush_i) begin
            m_pc = branch_target_i & ~32'h3;
            m_pc_o = 0; m_inst = BUBBLE; m_valid = 0;
            if (m_flc < CMAX) m_flc++;
        end else if (!stall_i) begin
            m_pc_o = m_pc; m_inst = imem_word(m_pc); m_valid = 1;
            m_pc = m_pc + 4;
            if (m_fc < CMAX) m_fc++;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk_i);
        model_edge();
        #1;
        chk({tag, ".addr"}, imem_addr_o, m_pc);
        chk({tag, ".pc_o"}, pc_o, m_pc_o);
        chk({tag, ".inst"}, inst_o, m_inst);
        chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, m_valid});
        chk({tag, ".fcnt"}, {28'b0, fetch_count_o}, m_fc);
        chk({tag, ".flcnt"}, {28'b0, flush_count_o}, m_flc);
    endtask

    task automatic drive(input logic r, input logic s, input logic st, input logic f,
                         input logic [31:0] t);
        rst_i = r; start_i = s; stall_i = st; flush_i = f; branch_target_i = t;
    endtask

    initial begin
        m_pc = 0; m_pc_o = 0; m_inst = 0; m_valid = 0; m_fc = 0; m_flc = 0;
        drive(1, 0, 0, 0, 0);
        step("reset");
        chk("reset.addr_const", imem_addr_o, RST_PC);

        // Plan 1: two sequential fetches
        drive(0, 1, 0, 0, 0);
        step("p1.e1");
        chk("p1.e1.inst_const", inst_o, 32'h00A0_0093);
        step("p1.e2");
        chk("p1.e2.inst_const", inst_o, 32'h0010_0113);
        chk("p1.e2.fcnt_const", {28'b0, fetch_count_o}, 32'd2);

        // Plan 2: three-cycle stall at pc=8
        drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("p2.stall");
            chk("p2.addr_const", imem_addr_o, 32'h8);
            chk("p2.pc_o_const", pc_o, 32'h4);
        end
        drive(0, 1, 0, 0, 0);
        step("p2.release");
        chk("p2.release.pc_o_const", pc_o, 32'h8);
        step("p2.to10");

        // Plan 3: flush to 0x40 from pc=0x10
        drive(0, 1, 0, 1, 32'h40);
        step("p3.flush");
        chk("p3.addr_const", imem_addr_o, 32'h40);
        chk("p3.flcnt_const", {28'b0, flush_count_o}, 32'd1);
        drive(0, 1, 0, 0, 0);
        step("p3.after");
        chk("p3.after.pc_o_const", pc_o, 32'h40);

        // Plan 4: flush and stall together with a misaligned target
        drive(0, 1, 1, 1, 32'h23);
        step("p4.flush_stall");
        chk("p4.addr_const", imem_addr_o, 32'h20);

        // Plan 5: wrap at top of address space, then idle with flush ignored
        drive(0, 1, 0, 1, 32'hFFFF_FFFC);
        step("p5.redirect");
        drive(0, 1, 0, 0, 0);
        step("p5.wrap");
        chk("p5.wrap.addr_const", imem_addr_o, 32'h0);
        chk("p5.wrap.pc_o_const", pc_o, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1, 32'h80);
        step("p5.idle1");
        step("p5.idle2");
        chk("p5.idle.addr_const", imem_addr_o, 32'h0);

        // Plan 6: reset during a stall with a valid instruction held
        drive(0, 1, 0, 0, 0);
        step("p6.load");
        drive(1, 1, 1, 0, 0);
        step("p6.reset");
        chk("p6.valid_const", {31'b0, valid_o}, 32'd0);

        // Random control traffic; also drives the counters into saturation
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), $urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
